// File: rtl/led_chaser.sv
// LED chaser: a single lit LED walks forward, backward or ping-pongs across
// N_LED outputs, or all LEDs blink together. One step every
// (T_STEP >> speed) clock cycles while enabled; tick pulses for one cycle
// on every step. Reset forces a lamp test (all LEDs lit).
module led_chaser #(
    parameter int N_LED  = 4,
    parameter int T_STEP = 50_000_000,
    parameter int CNT_W  = 26,
    localparam int PW    = (N_LED > 1) ? $clog2(N_LED) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [1:0]       speed,
    output logic [N_LED-1:0] led,
    output logic [PW-1:0]    pos,
    output logic             tick
);

    typedef enum logic [1:0] {
        MODE_FWD   = 2'b00,
        MODE_REV   = 2'b01,
        MODE_PING  = 2'b10,
        MODE_BLINK = 2'b11
    } mode_e;

    // Pattern for pos 0: only the MSB lit; higher pos shifts it right.
    localparam logic [N_LED-1:0] LED_ONE = N_LED'(1);
    localparam logic [N_LED-1:0] LED_MSB = LED_ONE << (N_LED - 1);
    localparam logic [PW-1:0]    POS_MAX = PW'(N_LED - 1);
    localparam logic [PW-1:0]    POS_ONE = PW'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic             dir_q, dir_d;   // 0 = up, 1 = down (ping-pong only)
    logic             ph_q, ph_d;     // blink phase, 1 = lit
    logic             tick_q, tick_d;
    logic [N_LED-1:0] led_q, led_d;

    logic [31:0]      period_m1;
    logic             step;
    mode_e            mode_s;

    assign mode_s = mode_e'(mode);

    // Step timing and next-state for position, direction, phase and LEDs.
    always_comb begin
        // Compare with >= so a speed increase that leaves cnt beyond the
        // new terminal count steps on the very next cycle.
        period_m1 = (32'(T_STEP) >> speed) - 32'd1;
        step      = en && (32'(cnt_q) >= period_m1);

        cnt_d  = cnt_q;
        pos_d  = pos_q;
        dir_d  = dir_q;
        ph_d   = ph_q;
        tick_d = 1'b0;
        led_d  = led_q;

        if (en) begin
            if (step) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                unique case (mode_s)
                    MODE_FWD: begin
                        pos_d = (pos_q == POS_MAX) ? '0 : pos_q + POS_ONE;
                    end
                    MODE_REV: begin
                        pos_d = (pos_q == '0) ? POS_MAX : pos_q - POS_ONE;
                    end
                    MODE_PING: begin
                        // Endpoints bounce without repeating, and a stale
                        // dir left over from another mode is fixed here.
                        if (!dir_q) begin
                            if (pos_q >= POS_MAX) begin
                                dir_d = 1'b1;
                                pos_d = POS_MAX - POS_ONE;
                            end else begin
                                pos_d = pos_q + POS_ONE;
                            end
                        end else begin
                            if (pos_q == '0) begin
                                dir_d = 1'b0;
                                pos_d = POS_ONE;
                            end else begin
                                pos_d = pos_q - POS_ONE;
                            end
                        end
                    end
                    MODE_BLINK: begin
                        ph_d = ~ph_q;
                    end
                    default: begin
                        pos_d = pos_q;
                    end
                endcase
                // A single LED has nowhere to move.
                if (N_LED == 1) begin
                    pos_d = '0;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            // LEDs follow the current pos/phase/mode, one cycle behind.
            if (mode_s == MODE_BLINK) begin
                led_d = ph_q ? '1 : '0;
            end else begin
                led_d = LED_MSB >> pos_q;
            end
        end
    end

    // State registers; reset gives the lamp-test values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            pos_q  <= '0;
            dir_q  <= 1'b0;
            ph_q   <= 1'b1;
            tick_q <= 1'b0;
            led_q  <= '1;
        end else begin
            cnt_q  <= cnt_d;
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            ph_q   <= ph_d;
            tick_q <= tick_d;
            led_q  <= led_d;
        end
    end

    assign led  = led_q;
    assign pos  = pos_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_led_chaser.sv
// Bench for led_chaser with N_LED = 4, T_STEP = 8, CNT_W = 4, plus a
// single-LED instance driven by the same inputs.
module tb_led_chaser;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [1:0] speed;
    logic [3:0] led;
    logic [1:0] pos;
    logic       tick;
    logic       led1;
    logic       pos1;
    logic       tick1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_tick_cyc = 0;

    // Scoreboard entries: {pos, led}
    logic [5:0] exp_q[$];

    typedef struct {
        logic [1:0] mode;
        logic [1:0] pos;
        logic [3:0] led;
    } vec_t;

    vec_t vecs[20];

    led_chaser #(.N_LED(4), .T_STEP(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .speed(speed),
        .led(led), .pos(pos), .tick(tick)
    );

    led_chaser #(.N_LED(1), .T_STEP(8), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .speed(speed),
        .led(led1), .pos(pos1), .tick(tick1)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Wait for the next tick (bounded), check spacing and pos, then led one
    // cycle later against the scoreboard head.
    task automatic do_step(input int exp_gap, input string name);
        int n;
        logic [5:0] e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick !== 1'b1 && n < 64);
        e = exp_q.pop_front();
        if (tick !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s tick timeout actual=no_tick expected=tick", name);
            return;
        end
        chk({name, " gap"}, cyc - last_tick_cyc, exp_gap);
        last_tick_cyc = cyc;
        chk({name, " pos"}, 32'(pos), 32'(e[5:4]));
        chk({name, " pos1"}, 32'(pos1), 32'd0);
        chk({name, " tick1"}, 32'(tick1), 32'd1);
        @(negedge clk);
        chk({name, " led"}, 32'(led), 32'(e[3:0]));
        chk({name, " led1"}, 32'(led1), 32'(e[3:0] != 4'b0000));
        chk({name, " tick pulse"}, 32'(tick), 32'd0);
    endtask

    initial begin
        logic [1:0] fast_pos[4];
        logic [3:0] fast_led[4];
        logic [5:0] e;

        // Stimulus table: mode applied, expected pos at tick, led next cycle
        vecs[0]  = '{2'd0, 2'd1, 4'b0100};
        vecs[1]  = '{2'd0, 2'd2, 4'b0010};
        vecs[2]  = '{2'd0, 2'd3, 4'b0001};
        vecs[3]  = '{2'd0, 2'd0, 4'b1000};
        vecs[4]  = '{2'd1, 2'd3, 4'b0001};
        vecs[5]  = '{2'd1, 2'd2, 4'b0010};
        vecs[6]  = '{2'd1, 2'd1, 4'b0100};
        vecs[7]  = '{2'd1, 2'd0, 4'b1000};
        vecs[8]  = '{2'd2, 2'd1, 4'b0100};
        vecs[9]  = '{2'd2, 2'd2, 4'b0010};
        vecs[10] = '{2'd2, 2'd3, 4'b0001};
        vecs[11] = '{2'd2, 2'd2, 4'b0010};
        vecs[12] = '{2'd2, 2'd1, 4'b0100};
        vecs[13] = '{2'd2, 2'd0, 4'b1000};
        vecs[14] = '{2'd2, 2'd1, 4'b0100};
        vecs[15] = '{2'd2, 2'd2, 4'b0010};
        vecs[16] = '{2'd3, 2'd2, 4'b0000};
        vecs[17] = '{2'd3, 2'd2, 4'b1111};
        vecs[18] = '{2'd3, 2'd2, 4'b0000};
        vecs[19] = '{2'd3, 2'd2, 4'b1111};

        // Reset: lamp test
        rst = 1'b1; en = 1'b1; mode = 2'd0; speed = 2'd0;
        repeat (3) @(negedge clk);
        chk("reset led", 32'(led), 32'hF);
        chk("reset pos", 32'(pos), 32'd0);
        chk("reset tick", 32'(tick), 32'd0);
        rst = 1'b0;
        last_tick_cyc = cyc;
        @(negedge clk);
        chk("first led", 32'(led), 32'h8);
        chk("first pos", 32'(pos), 32'd0);

        // Table-driven sweep through all four modes
        for (int i = 0; i < 20; i++) begin
            if (vecs[i].mode != mode) begin
                mode = vecs[i].mode;
                if (mode == 2'd3) begin
                    @(negedge clk);
                    chk("mode11 switch led", 32'(led), 32'hF);
                end
            end
            exp_q.push_back({vecs[i].pos, vecs[i].led});
            do_step(8, $sformatf("vec%0d", i));
        end

        // Enable freeze at cnt = 3 for 20 cycles
        mode = 2'd0;
        exp_q.push_back({2'd3, 4'b0001});
        do_step(8, "pre_freeze");
        repeat (2) @(negedge clk);
        en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk($sformatf("freeze%0d tick", k), 32'(tick), 32'd0);
            chk($sformatf("freeze%0d led", k), 32'(led), 32'h1);
            chk($sformatf("freeze%0d pos", k), 32'(pos), 32'd3);
        end
        en = 1'b1;
        last_tick_cyc = cyc;
        exp_q.push_back({2'd0, 4'b1000});
        do_step(5, "resume");

        // Speed 0 -> 3 at cnt = 5
        repeat (4) @(negedge clk);
        speed = 2'd3;
        @(negedge clk);
        chk("speedup tick", 32'(tick), 32'd1);
        chk("speedup gap", cyc - last_tick_cyc, 32'd6);
        chk("speedup pos", 32'(pos), 32'd1);
        last_tick_cyc = cyc;
        fast_pos = '{2'd2, 2'd3, 2'd0, 2'd1};
        fast_led = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
        for (int k = 0; k < 4; k++) exp_q.push_back({fast_pos[k], fast_led[k]});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("fast%0d tick", k), 32'(tick), 32'd1);
            chk($sformatf("fast%0d gap", k), cyc - last_tick_cyc, 32'd1);
            chk($sformatf("fast%0d pos", k), 32'(pos), 32'(e[5:4]));
            chk($sformatf("fast%0d led", k), 32'(led), 32'(e[3:0]));
            last_tick_cyc = cyc;
        end
        speed = 2'd0;

        // Blink, then reset mid-period
        mode = 2'd3;
        exp_q.push_back({2'd1, 4'b0000});
        do_step(8, "blink_pre_rst");
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async rst led", 32'(led), 32'hF);
        chk("async rst pos", 32'(pos), 32'd0);
        chk("async rst tick", 32'(tick), 32'd0);
        @(negedge clk);
        chk("held rst led", 32'(led), 32'hF);
        rst = 1'b0;
        last_tick_cyc = cyc;
        @(negedge clk);
        chk("blink first led", 32'(led), 32'hF);
        exp_q.push_back({2'd0, 4'b0000});
        do_step(8, "blink_post_rst0");
        exp_q.push_back({2'd0, 4'b1111});
        do_step(8, "blink_post_rst1");

        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
